// File: rtl/fifo_uart_tx.sv
// Purpose : UART transmitter draining a show-ahead FIFO onto a serial TX line.
// Latency : fifo_re pop edge -> start bit on tx the next cycle; frame = bits*(divisor+1) cycles.
// Backpr. : pops only when idle, enabled and FIFO non-empty; one pop per frame.
//
// Ports:
//   clk, reset        - clock, async active-low reset
//   en                - transmit enable, sampled only while idle
//   divisor           - bit period minus one, in clk cycles
//   parity_en/_odd    - append parity bit / select odd parity
//   stop2             - two stop bits when set
//   fifo_empty/_dout  - FIFO read side (dout is the current front element)
//   fifo_re           - combinational pop strobe to the FIFO
//   tx, busy          - registered serial line (idle high) and frame-in-progress flag
module fifo_uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_re,
  output logic                 tx,
  output logic                 busy
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 pop;
  logic                 bit_end;

  // Gated by reset so the FIFO is never popped while the block is held in reset.
  assign pop     = reset & (state_q == IDLE) & en & ~fifo_empty;
  assign fifo_re = pop;
  assign bit_end = (baud_q == '0);
  assign tx      = tx_q;
  assign busy    = busy_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (pop) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_q == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        // Second stop bit only when two were requested and the first is done.
        if (bit_end && !(stop2_q && !stop_cnt_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, frame settings and shift register.
  always_comb begin
    shift_d    = shift_q;
    par_d      = par_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_cnt_d = stop_cnt_q;

    if (state_q == IDLE) begin
      baud_d     = '0;
      bit_d      = '0;
      stop_cnt_d = 1'b0;
      if (pop) begin
        // Frame settings are frozen here; later input changes are ignored.
        shift_d  = fifo_dout;
        par_d    = (^fifo_dout) ^ parity_odd;
        div_d    = divisor;
        par_en_d = parity_en;
        stop2_d  = stop2;
        baud_d   = divisor;
      end
    end else begin
      baud_d = bit_end ? div_q : (baud_q - DIV_WIDTH'(1));
      if (bit_end) begin
        if (state_q == DATA) begin
          shift_d = shift_q >> 1;
          bit_d   = (bit_q == LAST_BIT) ? '0 : (bit_q + BIT_W'(1));
        end
        if (state_q == STOP) begin
          stop_cnt_d = ~stop_cnt_q;
        end
      end
    end
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = shift_d[0];
      PARITY:  tx_d   = par_d;
      STOP:    tx_d   = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a small FIFO model feeds bytes, tx/busy/fifo_re are
// compared cycle by cycle against frames built from hand-written settings.
module tb_fifo_uart_tx;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] divisor;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_re;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model: bench writes mem/wr_ptr, the pop process owns rd_ptr.
  logic [7:0]  mem [16];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;
  int          pops   = 0;

  int mid_cycle = -1;
  int mid_div   = 0;
  bit mid_en    = 1'b1;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr[3:0]];

  fifo_uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .divisor    (divisor),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_re) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1;
    #1;
  endtask

  // Waits (bounded) for a pop, then checks every cycle of the frame and the idle cycle after it.
  task automatic frame(input logic [7:0] b, input int div, input bit pe, input bit po,
                       input bit s2, output int waited);
    logic bits [12];
    int   nb;
    int   k;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = b[i];
    if (pe) bits[nb++] = (^b) ^ po;
    bits[nb++] = 1'b1;
    if (s2) bits[nb++] = 1'b1;

    waited = 0;
    while (!fifo_re && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("pop_seen", {31'd0, fifo_re}, 32'd1);

    k = 0;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        k++;
        if (k == mid_cycle) begin
          divisor = mid_div[15:0];
          en      = mid_en;
        end
        chk("tx_bit", {31'd0, tx}, {31'd0, bits[i]});
        chk("busy_frame", {31'd0, busy}, 32'd1);
        chk("re_in_frame", {31'd0, fifo_re}, 32'd0);
      end
    end
    @(negedge clk);
    chk("idle_tx", {31'd0, tx}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk({tag, "_re"}, {31'd0, fifo_re}, 32'd0);
      chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int w;
    reset      = 1'b0;
    en         = 1'b1;
    divisor    = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;

    // Reset held with data waiting: no pop, line idle.
    push(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_re", {31'd0, fifo_re}, 32'd0);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("re_after_rst", {31'd0, fifo_re}, 32'd1);

    // 0xA5, divisor 3, no parity, one stop: 40 cycles.
    frame(8'hA5, 3, 1'b0, 1'b0, 1'b0, w);
    chk("pops_a", pops, 1);

    // Even parity, then odd parity with two stop bits.
    parity_en = 1'b1;
    push(8'hA5);
    frame(8'hA5, 3, 1'b1, 1'b0, 1'b0, w);
    parity_odd = 1'b1;
    stop2      = 1'b1;
    push(8'hA5);
    frame(8'hA5, 3, 1'b1, 1'b1, 1'b1, w);
    chk("pops_b", pops, 3);

    // Three back-to-back frames at divisor 0, one idle cycle between them.
    en         = 1'b0;
    divisor    = 16'd0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    en = 1'b1;
    #1;
    frame(8'h00, 0, 1'b0, 1'b0, 1'b0, w);
    chk("gap_0", w, 0);
    frame(8'hFF, 0, 1'b0, 1'b0, 1'b0, w);
    chk("gap_1", w, 0);
    frame(8'h3C, 0, 1'b0, 1'b0, 1'b0, w);
    chk("gap_2", w, 0);
    chk("fifo_empty_after", {31'd0, fifo_empty}, 32'd1);
    chk("pops_c", pops, 6);
    quiet(15, "no_4th_pop");

    // Divisor change during DATA applies only to the following frame.
    en      = 1'b0;
    divisor = 16'd3;
    push(8'h3C);
    push(8'hC3);
    en        = 1'b1;
    mid_cycle = 15;
    mid_div   = 7;
    mid_en    = 1'b1;
    #1;
    frame(8'h3C, 3, 1'b0, 1'b0, 1'b0, w);
    mid_cycle = -1;
    frame(8'hC3, 7, 1'b0, 1'b0, 1'b0, w);
    chk("gap_div", w, 0);
    chk("pops_d", pops, 8);

    // en dropped mid-frame: frame completes, queued byte stays.
    en      = 1'b0;
    divisor = 16'd1;
    push(8'h81);
    push(8'h7E);
    en        = 1'b1;
    mid_cycle = 6;
    mid_div   = 1;
    mid_en    = 1'b0;
    #1;
    frame(8'h81, 1, 1'b0, 1'b0, 1'b0, w);
    mid_cycle = -1;
    quiet(30, "en_off");
    chk("pops_e", pops, 9);
    wr_ptr = rd_ptr;

    // Reset during DATA bit 4 of 0xA5 aborts the frame at once.
    divisor = 16'd3;
    en      = 1'b1;
    push(8'hA5);
    w = 0;
    while (!fifo_re && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("pop_before_abort", {31'd0, fifo_re}, 32'd1);
    repeat (21) @(negedge clk);
    chk("tx_data_bit4", {31'd0, tx}, 32'd0);
    #2;
    reset  = 1'b0;
    wr_ptr = rd_ptr;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_re", {31'd0, fifo_re}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    quiet(20, "post_abort");
    chk("pops_f", pops, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
UART transmit engine that drains the team's synchronous FIFO from its read side and serialises each byte onto a single TX line (start, 8 data LSB-first, optional parity, 1 or 2 stop bits). It sits between the peripheral's TX FIFO and the pad.
- It consumes the FIFO's `empty`, `dout` and `re` signals directly.
- It uses the FIFO's show-ahead behaviour: `dout` is always the current front element, and asserting `re` pops it on the clock edge.

Parameters:
DATA_BITS, 8, payload bits per frame (must equal the FIFO XLEN it is connected to)
DIV_WIDTH, 16, width of baud divisor input

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  transmitter enable; sampled only in IDLE
divisor  input  DIV_WIDTH  bit period minus one, in clk cycles
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even
stop2  input  1  1 = two stop bits, 0 = one
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_BITS  FIFO front element (combinational, show-ahead)
fifo_re  output  1  pop strobe to FIFO
tx  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, tx=1, busy=0, all counters=0.
  - fifo_re forced 0 for as long as reset=0.
  - Reset mid-frame aborts the frame immediately: tx returns high, and no further pop occurs.
- fifo_re is combinational: fifo_re = reset & (state==IDLE) & en & !fifo_empty. It is high for exactly one cycle per frame.
- On the clk edge where fifo_re=1:
  - fifo_dout is loaded into the shift register.
  - divisor, parity_en, parity_odd and stop2 are latched for the whole frame.
  - Parity is computed from the loaded byte: XOR of the data bits, inverted if odd.
  - State moves to START, busy=1.
- Input changes mid-frame have no effect. Deasserting en mid-frame lets the current frame complete.
- States:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right after each bit; bit counter 0..DATA_BITS-1.
  - PARITY: only if parity_en latched; tx=parity.
  - STOP: tx=1; 1 or 2 bit periods per stop2 latched.
  - Transitions: IDLE->START->DATA->(PARITY)->STOP->IDLE.
- Bit timing:
  - tx is registered. The first start-bit cycle is the cycle after the pop edge.
  - Each bit is driven for exactly divisor_latched+1 clk cycles. The baud counter counts down from divisor to 0, then the bit advances. divisor=0 gives 1 cycle per bit.
- Frame length = (1 + DATA_BITS + parity_en + 1 + stop2) × (divisor+1) cycles.
- After the last stop cycle the state returns to IDLE, with tx=1 and busy=0 for at least one clk cycle. The next pop may occur in that IDLE cycle, so the inter-frame gap is exactly 1 clk cycle when the FIFO is non-empty.
- busy is registered: 1 from the cycle after the pop through the last stop cycle.
- The block never pops when fifo_empty=1. FIFO wrap-around is transparent to this block.
- Counter widths: baud counter DIV_WIDTH bits, bit counter clog2(DATA_BITS) bits. No overflow is possible under these rules.

Test Plan:
- Reset held low with fifo_empty=0 and en=1 -> fifo_re=0, tx=1, busy=0 throughout. Release reset -> fifo_re=1 in the first cycle, busy=1 on the next cycle.
- FIFO holds 0xA5, divisor=3, parity_en=0, stop2=0 -> one pop. tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total), then tx=1 and busy=0.
- Same byte with parity_en=1: parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1. With stop2=1 the frame is 12 bits = 48 cycles at divisor=3.
- FIFO preloaded with 0x00, 0xFF, 0x3C at divisor=0 -> three pops. Frames are 10 cycles each, separated by exactly 1 idle-high cycle. fifo_empty rises after the third pop, and no fourth pop occurs.
- Mid-frame events:
  - divisor changed 3->7 during DATA: the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
  - en dropped mid-frame: the frame completes and no new pop follows.
- Reset asserted during the DATA bit 4 of 0xA5 -> tx=1 within the same cycle (async). After release, the FIFO (also reset) is empty, and no pop or start bit appears.
